alu_seq: RTL and testbench

Sequencing front-end for the 32-bit `alu` block. It accepts register-register instructions over a valid/ready handshake and reads operands from an internal register file. It drives the ALU operand/select ports, captures the ALU result, and writes it back. It is the initiator for the combinational ALU responder and is the piece the lab datapath uses to run ALU programs from a testbench or small instruction source.

---
 rtl/alu_seq.sv | 167 ++++++++++++++++
 tb/tb_alu_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Brief    : Four-phase sequencer feeding an external 32-bit ALU. It reads
//             operands from a small register file and writes the result back.
//  Revision : 1.0
// ============================================================================
module alu_seq #(
   parameter int WIDTH = 32,
   parameter int NREG  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [12:0]      instr,
   input  logic             ld_valid,
   input  logic [2:0]       ld_addr,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [3:0]       S,
   input  logic [WIDTH-1:0] O,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   input  logic [2:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OPND = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic [3:0]       s_q,      s_d;
   logic [3:0]       op_q,     op_d;
   logic [2:0]       rd_q,     rd_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q,   done_d;
   logic             err_q,    err_d;
   logic [WIDTH-1:0] regs_q [NREG];
   logic [WIDTH-1:0] regs_d [NREG];

   logic [3:0]       w_op;
   logic [2:0]       w_rd;
   logic [2:0]       w_rs1;
   logic [2:0]       w_rs2;
   logic [WIDTH-1:0] w_rs1_val;
   logic [WIDTH-1:0] w_rs2_val;
   logic             w_accept;

   assign w_op  = instr[12:9];
   assign w_rd  = instr[8:6];
   assign w_rs1 = instr[5:3];
   assign w_rs2 = instr[2:0];

   // Register 0 is hardwired to zero on every read path.
   assign w_rs1_val = (w_rs1 == 3'd0) ? '0 : regs_q[w_rs1];
   assign w_rs2_val = (w_rs2 == 3'd0) ? '0 : regs_q[w_rs2];
   assign dbg_data  = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

   assign instr_ready = (state_q == ST_IDLE) && !rst;
   assign w_accept    = instr_valid && instr_ready;

   assign A      = a_q;
   assign B      = b_q;
   assign S      = s_q;
   assign done   = done_q;
   assign err    = err_q;
   assign result = result_q;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      op_d     = op_q;
      rd_d     = rd_q;
      result_d = result_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_op[3]) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  a_d     = w_rs1_val;
                  b_d     = w_rs2_val;
                  op_d    = w_op;
                  rd_d    = w_rd;
                  state_d = ST_OPND;
               end
            end
         end
         // Select changes only after the operands have been stable a cycle.
         ST_OPND: begin
            s_d     = op_q;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            result_d = O;
            s_d      = 4'd0;
            done_d   = 1'b1;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Writeback is applied after the load so it wins on a same-register clash.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (ld_valid && (ld_addr != 3'd0)) begin
         regs_d[ld_addr] = ld_data;
      end
      if ((state_q == ST_EXEC) && (rd_q != 3'd0)) begin
         regs_d[rd_q] = O;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= 4'd0;
         op_q     <= 4'd0;
         rd_q     <= 3'd0;
         result_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         done_q   <= done_d;
         err_q    <= err_d;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Brief    : Scoreboard bench for alu_seq with a behavioural ALU responder.
//  Revision : 1.0
// ============================================================================
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [12:0] instr = '0;
   logic        ld_valid = 1'b0;
   logic [2:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic [31:0] A, B, O, result, dbg_data;
   logic [3:0]  S;
   logic        done, err;
   logic [2:0]  dbg_addr = '0;

   typedef struct {
      logic [31:0] val;
      logic        is_err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_reg [8];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32), .NREG(8)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .A(A), .B(B), .S(S), .O(O), .done(done), .err(err), .result(result),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
      case (s)
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a << 1;
         4'd4:    return a >> 1;
         4'd5:    return a & b;
         4'd6:    return a | b;
         4'd7:    return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   // Combinational ALU responder
   assign O = alu_f(A, B, S);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] a, input logic [31:0] d);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_valid = 1'b0;
      if (a != 3'd0) m_reg[a] = d;
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = i[2:0];
         #1;
         n_checks++;
         if (dbg_data !== m_reg[i]) begin
            n_fail++;
            $display("FAIL %s reg%0d got=%h exp=%h", tag, i, dbg_data, m_reg[i]);
         end
      end
   endtask

   task automatic pop_and_check(input string tag);
      exp_t e;
      n_checks++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s scoreboard empty got result=%h", tag, result);
      end else begin
         e = sb.pop_front();
         if (e.is_err) begin
            if (err !== 1'b1 || done !== 1'b1) begin
               n_fail++;
               $display("FAIL %s done/err got=%b%b exp=11", tag, done, err);
            end
         end else if (result !== e.val || done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s result got=%h done=%b err=%b exp=%h done=1 err=0",
                     tag, result, done, err, e.val);
         end
      end
   endtask

   // ld_cyc: -1 none, 0 load on the accept edge, 2 load on the writeback edge.
   task automatic issue(input string tag, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input int ld_cyc,
                        input logic [2:0] la, input logic [31:0] ld);
      logic [31:0] ea, eb, pa, pb, prev_res;
      exp_t e;
      ea = m_reg[rs1]; eb = m_reg[rs2];
      pa = A; pb = B; prev_res = result;
      n_checks++;
      if (instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s ready_before got=%b exp=1", tag, instr_ready);
      end
      instr_valid = 1'b1;
      instr = {op, rd, rs1, rs2};
      if (ld_cyc == 0) begin ld_valid = 1'b1; ld_addr = la; ld_data = ld; end
      e.val = alu_f(ea, eb, op); e.is_err = op[3];
      sb.push_back(e);
      tick();
      // Still offering a different word while busy; it must be ignored.
      instr = {4'd1, 3'd7, 3'd1, 3'd1};
      ld_valid = 1'b0;
      if (ld_cyc == 0 && la != 3'd0) m_reg[la] = ld;
      if (op[3]) begin
         instr_valid = 1'b0;
         pop_and_check(tag);
         n_checks++;
         if (S !== 4'd0 || A !== pa || B !== pb || instr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s illegal_hold got A=%h B=%h S=%h rdy=%b exp A=%h B=%h S=0 rdy=0",
                     tag, A, B, S, instr_ready, pa, pb);
         end
         tick();
         n_checks++;
         if (done !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1 || result !== prev_res) begin
            n_fail++;
            $display("FAIL %s illegal_after got done=%b err=%b rdy=%b res=%h exp 0 0 1 %h",
                     tag, done, err, instr_ready, result, prev_res);
         end
         return;
      end
      n_checks++;
      if (A !== ea || B !== eb || S !== 4'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s opnd got A=%h B=%h S=%h done=%b exp A=%h B=%h S=0 done=0",
                  tag, A, B, S, done, ea, eb);
      end
      tick();
      n_checks++;
      if (A !== ea || B !== eb || S !== op || done !== 1'b0 || result !== prev_res) begin
         n_fail++;
         $display("FAIL %s exec got A=%h B=%h S=%h done=%b res=%h exp S=%h done=0 res=%h",
                  tag, A, B, S, done, result, op, prev_res);
      end
      if (ld_cyc == 2) begin ld_valid = 1'b1; ld_addr = la; ld_data = ld; end
      tick();
      ld_valid = 1'b0;
      instr_valid = 1'b0;
      if (ld_cyc == 2 && la != 3'd0) m_reg[la] = ld;
      if (rd != 3'd0) m_reg[rd] = e.val;
      pop_and_check(tag);
      n_checks++;
      if (S !== 4'd0 || A !== ea || B !== eb || instr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_cyc got S=%h A=%h B=%h rdy=%b exp S=0 A=%h B=%h rdy=0",
                  tag, S, A, B, instr_ready, ea, eb);
      end
      dbg_addr = rd;
      #1;
      n_checks++;
      if (dbg_data !== m_reg[rd]) begin
         n_fail++;
         $display("FAIL %s writeback got=%h exp=%h", tag, dbg_data, m_reg[rd]);
      end
      tick();
      n_checks++;
      if (done !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s idle_return got done=%b err=%b rdy=%b exp 0 0 1",
                  tag, done, err, instr_ready);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (A !== 0 || B !== 0 || S !== 0 || result !== 0 || done !== 0 || err !== 0 ||
          instr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset got A=%h B=%h S=%h res=%h done=%b err=%b rdy=%b exp zeros rdy=1",
                  A, B, S, result, done, err, instr_ready);
      end
      check_regs("reset_regs");
   endtask

   task automatic test_arith();
      load(3'd1, 32'd5);
      load(3'd2, 32'd3);
      issue("add", 4'd1, 3'd3, 3'd1, 3'd2, -1, 3'd0, 32'd0);
      issue("sub_wrap", 4'd2, 3'd4, 3'd2, 3'd1, -1, 3'd0, 32'd0);
      load(3'd1, 32'h8000_0001);
      issue("shl1", 4'd3, 3'd1, 3'd1, 3'd0, -1, 3'd0, 32'd0);
      check_regs("arith_regs");
   endtask

   task automatic test_illegal();
      issue("illegal9", 4'd9, 3'd3, 3'd1, 3'd2, -1, 3'd0, 32'd0);
      issue("illegal15", 4'd15, 3'd5, 3'd4, 3'd4, -1, 3'd0, 32'd0);
      check_regs("illegal_regs");
   endtask

   task automatic test_reg0();
      load(3'd0, 32'h0000_DEAD);
      issue("add_rd0", 4'd1, 3'd0, 3'd1, 3'd1, -1, 3'd0, 32'd0);
      check_regs("reg0_regs");
   endtask

   task automatic test_hazards();
      issue("wb_wins", 4'd7, 3'd5, 3'd3, 3'd4, 2, 3'd5, 32'd7);
      issue("rd_before_wr", 4'd6, 3'd6, 3'd2, 3'd3, 0, 3'd2, 32'h0000_0100);
      check_regs("hazard_regs");
   endtask

   task automatic test_back_to_back();
      issue("b2b_and", 4'd5, 3'd7, 3'd4, 3'd5, -1, 3'd0, 32'd0);
      issue("b2b_shr1", 4'd4, 3'd7, 3'd7, 3'd0, -1, 3'd0, 32'd0);
      issue("b2b_zero", 4'd0, 3'd3, 3'd4, 3'd4, -1, 3'd0, 32'd0);
      check_regs("b2b_regs");
   endtask

   task automatic test_reset_mid();
      instr_valid = 1'b1;
      instr = {4'd1, 3'd6, 3'd4, 3'd4};
      tick();
      instr_valid = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      #1;
      n_checks++;
      if (A !== 0 || B !== 0 || S !== 0 || result !== 0 || done !== 0 || err !== 0) begin
         n_fail++;
         $display("FAIL reset_mid got A=%h B=%h S=%h res=%h done=%b err=%b exp zeros",
                  A, B, S, result, done, err);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         n_checks++;
         if (done !== 0 || S !== 0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_cyc%0d got done=%b S=%h rdy=%b exp 0 0 1",
                     c, done, S, instr_ready);
         end
      end
      check_regs("reset_mid_regs");
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got=%0d exp=0", sb.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_arith();
      test_illegal();
      test_reg0();
      test_hazards();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
